// File: rtl/mac512_pkg.sv
// Shared widths, state encoding and counter sizing for the MAC_512 serial accumulator.
package mac512_pkg;
    localparam int W      = 512;
    localparam int SLICE  = 32;
    localparam int NSLICE = W / SLICE;
    localparam int CNT_W  = $clog2(NSLICE);

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/serial_acc512_if.sv
// Operand/result bundle between the reduction stage and the serial accumulator.
interface serial_acc512_if;
    import mac512_pkg::*;

    // Operand transfer happens on a rising edge where in_valid & in_ready;
    // in_data/in_clear must be held stable by the master until that edge.
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_clear;
    logic [W-1:0] acc_out;
    logic         out_valid;
    logic         overflow;

    modport master (
        output in_valid, in_data, in_clear,
        input  in_ready, acc_out, out_valid, overflow
    );

    modport slave (
        input  in_valid, in_data, in_clear,
        output in_ready, acc_out, out_valid, overflow
    );
endinterface

// File: rtl/serial_acc512_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained through group generate/propagate.
module cla32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Ci,
    output logic [31:0] S,
    output logic        Cout
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic        w_cout;

    assign w_g = A & B;
    assign w_p = A ^ B;

    always_comb begin
        logic blk_c;
        logic blk_g;
        logic blk_p;
        w_c   = '0;
        blk_c = Ci;
        blk_g = 1'b0;
        blk_p = 1'b0;
        for (int b = 0; b < 8; b++) begin
            // Carries inside a group depend only on the group carry-in.
            w_c[4*b]   = blk_c;
            w_c[4*b+1] = w_g[4*b] | (w_p[4*b] & blk_c);
            w_c[4*b+2] = w_g[4*b+1] | (w_p[4*b+1] & w_g[4*b])
                       | (w_p[4*b+1] & w_p[4*b] & blk_c);
            w_c[4*b+3] = w_g[4*b+2] | (w_p[4*b+2] & w_g[4*b+1])
                       | (w_p[4*b+2] & w_p[4*b+1] & w_g[4*b])
                       | (w_p[4*b+2] & w_p[4*b+1] & w_p[4*b] & blk_c);
            blk_g = w_g[4*b+3] | (w_p[4*b+3] & w_g[4*b+2])
                  | (w_p[4*b+3] & w_p[4*b+2] & w_g[4*b+1])
                  | (w_p[4*b+3] & w_p[4*b+2] & w_p[4*b+1] & w_g[4*b]);
            blk_p = &w_p[4*b +: 4];
            blk_c = blk_g | (blk_p & blk_c);
        end
        w_cout = blk_c;
    end

    assign S    = w_p ^ w_c;
    assign Cout = w_cout;
endmodule

// File: rtl/serial_acc512.sv
// Serial 512-bit accumulator: one 32-bit slice per cycle through a single CLA32,
// carry held in a register between slices, 16 cycles per operand.
module serial_acc512 (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_acc512_if.slave            bus,
    output mac512_pkg::state_t        o_dbg_state
);
    import mac512_pkg::*;

    state_t       r_state;
    cnt_t         r_cnt;
    logic [W-1:0] r_op;
    logic [W-1:0] r_work;
    logic         r_carry;
    logic [W-1:0] r_acc;
    logic         r_out_valid;
    logic         r_overflow;
    logic         r_in_ready;

    logic [SLICE-1:0] w_sum;
    logic             w_cout;
    logic [W-1:0]     w_work_next;
    logic             w_last;

    cla32 u_cla32 (
        .A    (r_op[SLICE-1:0]),
        .B    (r_work[SLICE-1:0]),
        .Ci   (r_carry),
        .S    (w_sum),
        .Cout (w_cout)
    );

    // Completed slices enter at the top, so after NSLICE shifts slice 0 sits at the bottom.
    assign w_work_next = {w_sum, r_work[W-1:SLICE]};
    assign w_last      = (r_cnt == cnt_t'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_work      <= '0;
            r_carry     <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_op       <= bus.in_data;
                        r_work     <= bus.in_clear ? '0 : r_acc;
                        r_carry    <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ADD;
                        if (bus.in_clear) begin
                            r_overflow <= 1'b0;
                        end
                    end
                end
                ADD: begin
                    r_op    <= r_op >> SLICE;
                    r_work  <= w_work_next;
                    r_carry <= w_cout;
                    if (w_last) begin
                        // Carry out of the top slice only marks overflow; the sum wraps.
                        r_cnt       <= '0;
                        r_acc       <= w_work_next;
                        r_overflow  <= r_overflow | w_cout;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.acc_out   = r_acc;
    assign bus.out_valid = r_out_valid;
    assign bus.overflow  = r_overflow;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_serial_acc512.sv
// Bench for serial_acc512: vector table, stall / mid-add reset sequences, scoreboard on out_valid.
module tb_serial_acc512;
    import mac512_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    always #5 clk = ~clk;

    serial_acc512_if u_if ();

    serial_acc512 u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (u_if.slave),
        .o_dbg_state (dbg_state)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         clear;
        logic [W-1:0] exp_acc;
        logic         exp_ovf;
    } vec_t;

    vec_t         vecs [9];
    logic [W-1:0] exp_q[$];
    logic         exp_ovf_q[$];
    int           n_pass = 0;
    int           n_total = 0;
    logic [W-1:0] model_acc = '0;
    logic         model_ovf = 1'b0;
    logic [W-1:0] last_acc = '0;
    int           busy_cnt = 0;
    bit           abort = 1'b0;
    bit           prev_ov = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int i = 0; i < NSLICE; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: W+1 bit add, top bit feeds the sticky overflow.
    function automatic logic [W:0] model_next(input logic [W-1:0] d, input logic c);
        logic [W:0] s;
        if (c) return {1'b0, d};
        s = {1'b0, model_acc} + {1'b0, d};
        return {model_ovf | s[W], s[W-1:0]};
    endfunction

    task automatic push_exp(input logic [W-1:0] e_acc, input logic e_ovf);
        exp_q.push_back(e_acc);
        exp_ovf_q.push_back(e_ovf);
        model_acc = e_acc;
        model_ovf = e_ovf;
    endtask

    task automatic send(input logic [W-1:0] d, input logic c,
                        input logic [W-1:0] e_acc, input logic e_ovf);
        int waited = 0;
        @(negedge clk);
        while (!u_if.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!u_if.in_ready) begin
            n_total++;
            $display("FAIL ready_timeout: in_ready=%0d after %0d cycles, expected 1", u_if.in_ready, waited);
            return;
        end
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        u_if.in_clear = c;
        @(posedge clk);
        push_exp(e_acc, e_ovf);
        #1;
        u_if.in_valid = 1'b0;
        u_if.in_clear = 1'b1;
        u_if.in_data  = rand_word();
    endtask

    task automatic send_m(input logic [W-1:0] d, input logic c);
        logic [W:0] e;
        e = model_next(d, c);
        send(d, c, e[W-1:0], e[W]);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.out_valid) begin
                chk("out_valid_pulse", W'(prev_ov), W'(0));
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_out_valid: got acc %h with no result expected", u_if.acc_out);
                end else begin
                    last_acc = exp_q.pop_front();
                    chk("acc_out", u_if.acc_out, last_acc);
                    chk("overflow", W'(u_if.overflow), W'(exp_ovf_q.pop_front()));
                end
            end else if (!u_if.in_ready) begin
                chk("acc_stable", u_if.acc_out, last_acc);
            end
            if (!u_if.in_ready) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                if (!abort) chk("busy_len", W'(busy_cnt), W'(NSLICE));
                busy_cnt = 0;
                abort = 1'b0;
            end
            prev_ov = u_if.out_valid;
        end
    end

    initial begin
        logic [W-1:0] ones;
        logic [W:0]   e;
        int           waited;
        ones = '1;
        vecs[0] = '{512'd5,           1'b1, 512'd5,            1'b0};
        vecs[1] = '{512'd1,           1'b1, 512'd1,            1'b0};
        vecs[2] = '{512'hFFFF_FFFF,   1'b0, 512'h1_0000_0000,  1'b0};
        vecs[3] = '{ones,             1'b1, ones,              1'b0};
        vecs[4] = '{512'd1,           1'b0, 512'd0,            1'b1};
        vecs[5] = '{512'd7,           1'b1, 512'd7,            1'b0};
        vecs[6] = '{512'd10,          1'b1, 512'd10,           1'b0};
        vecs[7] = '{512'd20,          1'b0, 512'd30,           1'b0};
        vecs[8] = '{512'd30,          1'b0, 512'd60,           1'b0};

        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;
        u_if.in_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", W'(u_if.in_ready), W'(1));
        chk("rst_out_valid", W'(u_if.out_valid), W'(0));
        chk("rst_overflow", W'(u_if.overflow), W'(0));
        chk("rst_acc_out", u_if.acc_out, '0);
        chk("rst_state", W'(dbg_state), W'(IDLE));
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 9; i++) send(vecs[i].data, vecs[i].clear, vecs[i].exp_acc, vecs[i].exp_ovf);

        // Busy stall: in_valid stays high while in_data churns during ADD.
        @(negedge clk);
        waited = 0;
        while (!u_if.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        u_if.in_valid = 1'b1;
        u_if.in_clear = 1'b0;
        u_if.in_data  = rand_word();
        @(posedge clk);
        e = model_next(u_if.in_data, 1'b0);
        push_exp(e[W-1:0], e[W]);
        for (int i = 0; i < NSLICE; i++) begin
            #1 u_if.in_data = rand_word();
            @(posedge clk);
        end
        #1 u_if.in_data = rand_word();
        @(posedge clk);
        e = model_next(u_if.in_data, 1'b0);
        push_exp(e[W-1:0], e[W]);
        #1 u_if.in_valid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_m(rand_word(), 1'b0);
        end
        send_m(rand_word(), 1'b1);

        // Reset eight edges into an add: the operand is dropped, no out_valid follows.
        send_m(rand_word(), 1'b1);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        exp_ovf_q.delete();
        model_acc = '0;
        model_ovf = 1'b0;
        last_acc  = '0;
        abort     = 1'b1;
        @(negedge clk);
        chk("midrst_acc_out", u_if.acc_out, '0);
        chk("midrst_out_valid", W'(u_if.out_valid), W'(0));
        chk("midrst_in_ready", W'(u_if.in_ready), W'(1));
        chk("midrst_overflow", W'(u_if.overflow), W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", W'(u_if.in_ready), W'(1));
        repeat (20) @(negedge clk);
        send(512'd3, 1'b1, 512'd3, 1'b0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/serial_acc512.md
# serial_acc512

- Downstream consumer of the 32-bit carry-lookahead adder in the MAC_512 datapath.
- Accumulates a stream of 512-bit operands into a 512-bit running sum, one 32-bit slice per cycle, using a single CLA32 instance.
- Between slices the carry is held in a register, so one 512-bit add takes 16 cycles.
- Sits between the partial-product / reduction stage and the MAC result register.

## Interface
Parameters:
- W, 512: accumulator and operand width.
- SLICE, 32: adder slice width; W must be a multiple of SLICE. NSLICE = W/SLICE = 16.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand available.
- in_ready  output  1  block can accept an operand.
- in_data  input  W  operand to add.
- in_clear  input  1  sampled with the handshake; when 1 the sum restarts from zero (result = in_data).
- acc_out  output  W  last completed accumulator value.
- out_valid  output  1  one-cycle pulse when acc_out has just been updated.
- overflow  output  1  sticky; set by a carry out of the top slice.

## Operation
- FSM has two states:
  - IDLE: in_ready=1.
  - ADD: in_ready=0. Slice counter cnt counts 0..NSLICE-1.
- Handshake is in_valid & in_ready at a rising edge. On it:
  - op_reg <= in_data.
  - work_reg <= in_clear ? 0 : acc_out.
  - carry <= 0.
  - If in_clear, overflow <= 0.
  - cnt <= 0; state -> ADD.
- Each ADD cycle:
  - CLA32 adds op_reg[SLICE-1:0] + work_reg[SLICE-1:0] + carry.
  - op_reg shifts right by SLICE.
  - work_reg shifts right by SLICE, with the sum inserted at the top SLICE bits.
  - carry <= CLA32 Cout; cnt increments.
- On the edge where cnt = NSLICE-1:
  - acc_out <= completed work_reg, with the final sum slice inserted.
  - overflow <= overflow | Cout.
  - out_valid <= 1; state -> IDLE.
- Arithmetic is modulo 2^W; the carry out of the top slice is dropped except for setting overflow.
- in_valid while in ADD is not accepted. The upstream block holds in_data and in_valid until the handshake.
- acc_out is stable throughout ADD and changes only on the completion edge.
- in_clear is ignored when there is no handshake.

## Timing
- Reset values: in_ready=1, out_valid=0, overflow=0, acc_out=0, state=IDLE, cnt=0, carry=0.
- Reset asserted mid-ADD aborts the add immediately:
  - All outputs return to reset values.
  - The in-flight operand is lost.
  - No out_valid is produced.
- Handshake at edge T; slices 0..15 are processed at edges T+1..T+16.
- acc_out, out_valid and overflow update at edge T+16. out_valid is high for the single cycle after T+16.
- in_ready returns to 1 in that same cycle, so a new handshake at edge T+17 is allowed.
- Maximum throughput is one operand per 17 cycles.
- Back-to-back accumulation works without a bubble: the new operand sees the just-updated acc_out.

## Structure
- Shared package `mac512_pkg`:
  - W, SLICE, NSLICE constants.
  - State enum {IDLE, ADD}.
  - Counter width $clog2(NSLICE).
- One sub-module: the existing CLA32 adder, instantiated once with its Ci driven from the carry register.
  - Its Pout/Gout-free top (S, Cout) is used as-is.
- All remaining logic is local: FSM, counter, shift registers, output register.

## Test plan
- Reset then clear-add: in_data=5, in_clear=1 → out_valid at edge T+16, acc_out=5, overflow=0.
- Cross-slice carry: acc=1, add 0xFFFF_FFFF without clear → acc_out = 0x1_0000_0000 (bit 32 set, low 32 bits zero).
- Full ripple overflow: acc = all ones (2^512-1), add 1 → acc_out=0, overflow=1. A subsequent clear-add of 7 → acc_out=7, overflow=0.
- Back-to-back: three handshakes at T, T+17, T+34 adding 10, 20, 30 after a clear → acc_out reads 10, 30, 60 on successive out_valid pulses; in_ready low exactly 16 cycles each.
- Busy stall: in_valid held high during ADD with a changing in_data → only the value present at the T+17 handshake is accepted; the sum matches the reference model.
- Reset mid-operation: rst_n pulsed low at cycle T+8 → acc_out=0, out_valid never pulses, in_ready=1 immediately after release; the next clear-add of 3 → acc_out=3.
